// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB chunk first, registered carry.
// Define SEQ_ADDSUB_SATURATE_EN to clamp overflowing results to the signed limit.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             addsub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ov_flag,
    output logic             zero_flag
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic             carry_reg;
    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ov_reg;
    logic             zero_reg;

    logic [CHUNK-1:0] a_chunks  [NCHUNK];
    logic [CHUNK-1:0] bx_chunks [NCHUNK];
    logic [WIDTH-1:0] s_upd;
    logic [WIDTH-1:0] s_final;
    logic [CHUNK:0]   sum;
    logic             ov_raw;
    logic             last_chunk;

    // Slice the latched operands into chunks and merge the current chunk sum into the result.
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign a_chunks[gi]  = a_reg[gi*CHUNK +: CHUNK];
        assign bx_chunks[gi] = bx_reg[gi*CHUNK +: CHUNK];
        assign s_upd[gi*CHUNK +: CHUNK] = (idx_reg == IDXW'(gi)) ? sum[CHUNK-1:0]
                                                                 : s_reg[gi*CHUNK +: CHUNK];
    end

    assign sum = {1'b0, a_chunks[idx_reg]} + {1'b0, bx_chunks[idx_reg]}
               + {{CHUNK{1'b0}}, carry_reg};

    assign last_chunk = (idx_reg == LAST_IDX);

    // Only meaningful on the last chunk, where sum[CHUNK-1] is the result MSB.
    assign ov_raw = (a_reg[WIDTH-1] == bx_reg[WIDTH-1]) && (sum[CHUNK-1] != a_reg[WIDTH-1]);

`ifdef SEQ_ADDSUB_SATURATE_EN
    assign s_final = ov_raw ? {a_reg[WIDTH-1], {(WIDTH-1){~a_reg[WIDTH-1]}}} : s_upd;
`else
    assign s_final = s_upd;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_RUN;
            ST_RUN:  if (last_chunk) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            bx_reg    <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ov_reg    <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        bx_reg    <= B ^ {WIDTH{addsub}};
                        carry_reg <= addsub;
                        idx_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    carry_reg <= sum[CHUNK];
                    idx_reg   <= idx_reg + IDXW'(1);
                    if (last_chunk) begin
                        s_reg    <= s_final;
                        cout_reg <= sum[CHUNK];
                        ov_reg   <= ov_raw;
                        zero_reg <= (s_final == '0);
                    end else begin
                        s_reg <= s_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign S         = s_reg;
    assign Cout      = cout_reg;
    assign ov_flag   = ov_reg;
    assign zero_flag = zero_reg;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and random checks of seq_addsub at WIDTH=16, CHUNK=4, including timing, backpressure and reset.
module tb_seq_addsub;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             addsub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov_flag;
    logic             zero_flag;

    int errors = 0;
    int checks = 0;

    seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .addsub    (addsub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Cout      (cout),
        .ov_flag   (ov_flag),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             mode;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] s_sat;
        logic             c;
        logic             ov;
        logic             z;
        logic             z_sat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Counts negedges from the one after the accept edge until out_valid; in_ready must stay low.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                          input logic mode_i, output int lat, output logic busy_ok);
        int n;
        @(negedge clk);
        a = a_i; b = b_i; addsub = mode_i; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~a_i; b = a_i ^ 16'h5A5A; addsub = ~mode_i;
        wait_done(lat, busy_ok);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic busy_ok;
        logic [WIDTH-1:0] ra, rb, bx, es;
        logic [WIDTH:0] full;
        logic rm, ec, eov, ez;

        //                a         b         m     s         s_sat     c     ov    z     z_sat
        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{16'h0001, 16'h8000, 1'b1, 16'h8001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", {16'd0, s}, 32'd0);
        chk("rst_flags", {29'd0, cout, ov_flag, zero_flag}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            logic [WIDTH-1:0] exp_s;
            logic exp_z;
`ifdef SEQ_ADDSUB_SATURATE_EN
            exp_s = vecs[i].s_sat;
            exp_z = vecs[i].z_sat;
`else
            exp_s = vecs[i].s;
            exp_z = vecs[i].z;
`endif
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, lat, busy_ok);
            $display("vec %0d: A=%h B=%h mode=%0d -> S=%h C=%0d V=%0d Z=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].mode, s, cout, ov_flag, zero_flag, lat);
            chk($sformatf("vec%0d_latency", i), lat, NCHUNK + 1);
            chk($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
            chk($sformatf("vec%0d_s", i), {16'd0, s}, {16'd0, exp_s});
            chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].c});
            chk($sformatf("vec%0d_ov", i), {31'd0, ov_flag}, {31'd0, vecs[i].ov});
            chk($sformatf("vec%0d_zero", i), {31'd0, zero_flag}, {31'd0, exp_z});
            finish_op();
        end

        // Backpressure: result held while out_ready low; in_valid held high across handshake.
        run_op(16'h1111, 16'h2222, 1'b0, lat, busy_ok);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_s_hold", {16'd0, s}, 32'h3333);
            chk("bp_flags_hold", {29'd0, cout, ov_flag, zero_flag}, 32'd0);
        end
        a = 16'h0100; b = 16'h0001; addsub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_no_passthru_in_ready", {31'd0, in_ready}, 32'd1);
        chk("hs_out_valid_low", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; addsub = 1'b0;
        wait_done(lat, busy_ok);
        $display("held-valid op: S=%h C=%0d lat=%0d", s, cout, lat);
        chk("hv_latency", lat, NCHUNK + 1);
        chk("hv_busy", {31'd0, busy_ok}, 32'd1);
        chk("hv_s", {16'd0, s}, 32'h00FF);
        chk("hv_cout", {31'd0, cout}, 32'd1);
        finish_op();

        // Reset on the 2nd RUN cycle discards the operation.
        @(negedge clk);
        a = 16'h7FFF; b = 16'h7FFF; addsub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-run reset: in_ready=%0d out_valid=%0d S=%h", in_ready, out_valid, s);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_s", {16'd0, s}, 32'd0);
        chk("mrst_flags", {29'd0, cout, ov_flag, zero_flag}, 32'd0);
        run_op(16'h0FF0, 16'h000F, 1'b0, lat, busy_ok);
        chk("post_rst_latency", lat, NCHUNK + 1);
        chk("post_rst_s", {16'd0, s}, 32'h0FFF);
        finish_op();

        // Random sweep against a full-width reference.
        for (int i = 0; i < 300; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rm = 1'($urandom_range(0, 1));
            bx = rb ^ {WIDTH{rm}};
            full = {1'b0, ra} + {1'b0, bx} + {{WIDTH{1'b0}}, rm};
            es = full[WIDTH-1:0];
            ec = full[WIDTH];
            eov = (ra[WIDTH-1] == bx[WIDTH-1]) && (es[WIDTH-1] != ra[WIDTH-1]);
`ifdef SEQ_ADDSUB_SATURATE_EN
            if (eov) es = {ra[WIDTH-1], {(WIDTH-1){~ra[WIDTH-1]}}};
`endif
            ez = (es == '0);
            run_op(ra, rb, rm, lat, busy_ok);
            $display("rand %0d: A=%h B=%h mode=%0d -> S=%h C=%0d V=%0d Z=%0d",
                     i, ra, rb, rm, s, cout, ov_flag, zero_flag);
            chk("rand_s", {16'd0, s}, {16'd0, es});
            chk("rand_flags", {29'd0, cout, ov_flag, zero_flag}, {29'd0, ec, eov, ez});
            finish_op();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
